wb_arbiter_intercon: RTL and testbench

WB_ARBITER_INTERCON -- requirements
Module: wb_arbiter_intercon

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_rr_arbiter.sv | 28 ++
 rtl/wb_arbiter_intercon.sv | 170 +++++++++++++++++
 tb/tb_wb_arbiter_intercon.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone arbiter/interconnect: default widths and FSM state encodings.
package wb_pkg;

  localparam int WB_NUM_MASTERS = 2;
  localparam int WB_NUM_SLAVES  = 5;
  localparam int WB_DATA_W      = 32;
  localparam int WB_ADDR_W      = 32;
  localparam int WB_SEL_LSB     = 28;
  localparam int WB_SEL_W       = 4;
  localparam int WB_TIMEOUT     = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ERROR = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin selector: grants the requester closest to ptr, counting upward with wrap.
module wb_rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  int best_d;
  int d;

  always_comb begin
    gnt    = '0;
    best_d = N;
    d      = 0;
    for (int i = 0; i < N; i++) begin
      d = (i + N - int'(ptr)) % N;
      if (req[i] && d < best_d) begin
        best_d = d;
        gnt    = '0;
        gnt[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_intercon.sv
// Wishbone N-master / M-slave shared-bus interconnect with round-robin arbitration.
// Optional slave ACK timeout enabled by defining WB_TIMEOUT_EN.
module wb_arbiter_intercon
  import wb_pkg::*;
#(
  parameter int NUM_MASTERS = WB_NUM_MASTERS,
  parameter int NUM_SLAVES  = WB_NUM_SLAVES,
  parameter int DATA_W      = WB_DATA_W,
  parameter int ADDR_W      = WB_ADDR_W,
  parameter int SEL_LSB     = WB_SEL_LSB,
  parameter int SEL_W       = WB_SEL_W,
  parameter int TIMEOUT     = WB_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_STB,
  input  logic [NUM_MASTERS-1:0]        m_WE,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_ADDR,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_DAT_I,
  output logic [NUM_MASTERS-1:0]        m_ACK,
  output logic [NUM_MASTERS-1:0]        m_ERR,
  output logic [DATA_W-1:0]             m_DAT_O,
  output logic [NUM_SLAVES-1:0]         s_STB,
  output logic [NUM_SLAVES-1:0]         s_WE,
  output logic [ADDR_W-1:0]             s_ADDR,
  output logic [DATA_W-1:0]             s_DAT_O,
  input  logic [NUM_SLAVES-1:0]         s_ACK,
  input  logic [NUM_SLAVES*DATA_W-1:0]  s_DAT_I,
  output logic [NUM_MASTERS-1:0]        grant
);

  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  wb_state_e              state, state_d;
  logic [PTR_W-1:0]       ptr, ptr_d, ptr_next;
  logic [NUM_MASTERS-1:0] grant_d, rr_gnt;
  logic [SEL_W-1:0]       slv_idx, slv_d, dec_idx;
  logic                   own_stb, own_we;
  logic [ADDR_W-1:0]      own_addr, req_addr;
  logic [DATA_W-1:0]      own_dat, sel_dat;
  logic                   sel_ack, busy_live, ack_live, timed_out;

  wb_rr_arbiter #(.N(NUM_MASTERS), .PTR_W(PTR_W)) u_rr (
    .req (m_STB),
    .ptr (ptr),
    .gnt (rr_gnt)
  );

  always_comb begin
    own_stb  = 1'b0;
    own_we   = 1'b0;
    own_addr = '0;
    own_dat  = '0;
    ptr_next = ptr;
    req_addr = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i]) begin
        own_stb  = m_STB[i];
        own_we   = m_WE[i];
        own_addr = m_ADDR[i*ADDR_W +: ADDR_W];
        own_dat  = m_DAT_I[i*DATA_W +: DATA_W];
        ptr_next = PTR_W'((i + 1) % NUM_MASTERS);
      end
      if (rr_gnt[i]) req_addr = m_ADDR[i*ADDR_W +: ADDR_W];
    end
    dec_idx = req_addr[SEL_LSB +: SEL_W];
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (slv_idx == SEL_W'(s)) begin
        sel_ack = s_ACK[s];
        sel_dat = s_DAT_I[s*DATA_W +: DATA_W];
      end
    end
  end

  // The slave strobe follows the owner's strobe live, so an abort drops it the same cycle.
  assign busy_live = (state == BUSY) && own_stb;
  assign ack_live  = busy_live && sel_ack;

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (busy_live && !sel_ack) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  assign timed_out = busy_live && !sel_ack && (cnt == CNT_W'(TIMEOUT - 1));
`else
  // Counter omitted: a transaction waits for ACK or abort indefinitely.
  assign timed_out = (TIMEOUT < 0);
`endif

  always_comb begin
    state_d = state;
    grant_d = grant;
    slv_d   = slv_idx;
    ptr_d   = ptr;
    unique case (state)
      IDLE: begin
        if (|m_STB) begin
          grant_d = rr_gnt;
          slv_d   = dec_idx;
          state_d = (int'(dec_idx) >= NUM_SLAVES) ? ERROR : BUSY;
        end
      end
      BUSY: begin
        if (!own_stb) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (sel_ack) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = ptr_next;
        end else if (timed_out) begin
          state_d = ERROR;
        end
      end
      ERROR: begin
        // Rotating past a failing master keeps it from monopolising the bus on retries.
        state_d = IDLE;
        grant_d = '0;
        ptr_d   = ptr_next;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= '0;
      grant   <= '0;
      slv_idx <= '0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      grant   <= grant_d;
      slv_idx <= slv_d;
    end
  end

  always_comb begin
    s_STB = '0;
    s_WE  = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (busy_live && slv_idx == SEL_W'(s)) begin
        s_STB[s] = 1'b1;
        s_WE[s]  = own_we;
      end
    end
  end

  assign s_ADDR  = busy_live ? own_addr : '0;
  assign s_DAT_O = busy_live ? own_dat : '0;
  assign m_ACK   = ack_live ? grant : '0;
  assign m_ERR   = (state == ERROR) ? grant : '0;
  assign m_DAT_O = ack_live ? sel_dat : '0;

endmodule

// File: tb/tb_wb_arbiter_intercon.sv
// Directed bench for wb_arbiter_intercon; the timeout scenario runs only when WB_TIMEOUT_EN is defined.
module tb_wb_arbiter_intercon;

  localparam int NM = 2;
  localparam int NS = 5;
  localparam int DW = 32;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NM-1:0]   m_STB = '0;
  logic [NM-1:0]   m_WE = '0;
  logic [NM*AW-1:0] m_ADDR = '0;
  logic [NM*DW-1:0] m_DAT_I = '0;
  logic [NM-1:0]   m_ACK, m_ERR;
  logic [DW-1:0]   m_DAT_O;
  logic [NS-1:0]   s_STB, s_WE;
  logic [AW-1:0]   s_ADDR;
  logic [DW-1:0]   s_DAT_O;
  logic [NS-1:0]   s_ACK = '0;
  logic [NS*DW-1:0] s_DAT_I = '0;
  logic [NM-1:0]   grant;

  int errors = 0;
  int checks = 0;

  wb_arbiter_intercon #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .DATA_W(DW), .ADDR_W(AW),
    .SEL_LSB(28), .SEL_W(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .m_STB(m_STB), .m_WE(m_WE), .m_ADDR(m_ADDR), .m_DAT_I(m_DAT_I),
    .m_ACK(m_ACK), .m_ERR(m_ERR), .m_DAT_O(m_DAT_O),
    .s_STB(s_STB), .s_WE(s_WE), .s_ADDR(s_ADDR), .s_DAT_O(s_DAT_O),
    .s_ACK(s_ACK), .s_DAT_I(s_DAT_I), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NM-1:0] exp_g;

    // Reset state
    #2;
    check("rst_grant", grant, 0);
    check("rst_s_stb", s_STB, 0);
    check("rst_m_ack", m_ACK, 0);
    check("rst_m_err", m_ERR, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Master 0 read from RAM, ACK on the third BUSY cycle
    m_STB = 2'b01; m_WE = 2'b00; m_ADDR[31:0] = 32'h0000_0010;
    #1;
    check("rd_idle_grant", grant, 0);
    check("rd_idle_s_stb", s_STB, 0);
    step();
    check("rd_c1_grant", grant, 2'b01);
    check("rd_c1_s_stb", s_STB, 5'b00001);
    check("rd_c1_s_addr", s_ADDR, 32'h0000_0010);
    check("rd_c1_m_ack", m_ACK, 0);
    step();
    check("rd_c2_s_stb", s_STB, 5'b00001);
    check("rd_c2_m_dat", m_DAT_O, 0);
    step();
    s_ACK = 5'b00001; s_DAT_I[31:0] = 32'hDEAD_BEEF;
    #1;
    check("rd_ack", m_ACK, 2'b01);
    check("rd_dat", m_DAT_O, 32'hDEAD_BEEF);
    check("rd_no_err", m_ERR, 0);
    step();
    m_STB = '0; s_ACK = '0;
    #1;
    check("rd_after_grant", grant, 0);
    check("rd_after_dat", m_DAT_O, 0);
    check("rd_after_s_stb", s_STB, 0);

    // Master 1 write to slave 1 (ptr now 1)
    m_STB = 2'b10; m_WE = 2'b10; m_ADDR[63:32] = 32'h1000_0000; m_DAT_I[63:32] = 32'h0000_1234;
    step();
    check("wr_grant", grant, 2'b10);
    check("wr_s_stb", s_STB, 5'b00010);
    check("wr_s_we", s_WE, 5'b00010);
    check("wr_s_dat", s_DAT_O, 32'h0000_1234);
    s_ACK = 5'b00010;
    #1;
    check("wr_ack", m_ACK, 2'b10);
    step();
    m_STB = '0; m_WE = '0; s_ACK = '0;

    // Abort by master 0 (ptr 0): strobe drops at once, ptr must stay at 0
    m_ADDR = '0;
    m_STB = 2'b01;
    step();
    check("ab_grant", grant, 2'b01);
    m_STB = 2'b00;
    #1;
    check("ab_s_stb_drop", s_STB, 0);
    step();
    check("ab_idle_grant", grant, 0);
    check("ab_no_err", m_ERR, 0);
    check("ab_no_ack", m_ACK, 0);

    // Both masters request continuously: 0,1,0,1,0,1
    m_STB = 2'b11;
    step();
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      check($sformatf("rr_grant_%0d", i), grant, exp_g);
      if (i == 0) begin
        step();
        check("rr_no_preempt", grant, 2'b01);
      end
      s_ACK = 5'b00001;
      #1;
      check($sformatf("rr_ack_%0d", i), m_ACK, exp_g);
      step();
      s_ACK = '0;
      if (i == 5) m_STB = '0;
      #1;
      check($sformatf("rr_gap_%0d", i), grant, 0);
      step();
    end

    // Unmapped slave index 7 -> single-cycle error, no slave strobe
    m_STB = 2'b01; m_ADDR[31:0] = 32'h7000_0000;
    step();
    check("err_s_stb", s_STB, 0);
    check("err_m_err", m_ERR, 2'b01);
    check("err_m_ack", m_ACK, 0);
    m_STB = '0;
    step();
    check("err_once", m_ERR, 0);
    check("err_idle_grant", grant, 0);

    // Reset during BUSY clears outputs without a clock edge
    m_STB = 2'b01; m_ADDR[31:0] = 32'h0000_0000;
    step();
    check("rb_s_stb", s_STB, 5'b00001);
    s_ACK = 5'b00001;
    #1;
    check("rb_ack_before", m_ACK, 2'b01);
    #1;
    reset = 1'b0;
    #1;
    check("rb_s_stb_async", s_STB, 0);
    check("rb_m_ack_async", m_ACK, 0);
    check("rb_grant_async", grant, 0);
    check("rb_m_err_async", m_ERR, 0);
    s_ACK = '0; m_STB = '0;
    step();
    reset = 1'b1;

`ifdef WB_TIMEOUT_EN
    // Slave never ACKs: error after 8 BUSY cycles
    m_STB = 2'b01; m_ADDR[31:0] = 32'h0000_0000;
    step();
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("to_busy_%0d", c), {s_STB, m_ERR}, {5'b00001, 2'b00});
      if (c < 8) step();
    end
    step();
    check("to_err", m_ERR, 2'b01);
    check("to_s_stb", s_STB, 0);
    m_STB = '0;
    step();
    check("to_idle_err", m_ERR, 0);
    check("to_idle_grant", grant, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
